// File: rtl/pc_sequencer_if.sv
// Bus between the D-stage decode / hazard unit (master) and the IF-stage PC sequencer (slave).
// fetch_valid qualifies pc: the IM word at pc is a new fetch exactly in cycles where fetch_valid=1; there is no ready, the IM always accepts.
interface pc_sequencer_if;
    logic        stall;
    logic        halt;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] d_pc;
    logic [25:0] d_imm;
    logic [31:0] d_rs;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        redirect;
    logic [31:0] link_addr;
    logic        halted;

    modport master (
        output stall, halt, npc_sel, br_taken, d_pc, d_imm, d_rs,
        input  pc, fetch_valid, redirect, link_addr, halted
    );

    modport slave (
        input  stall, halt, npc_sel, br_taken, d_pc, d_imm, d_rs,
        output pc, fetch_valid, redirect, link_addr, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// IF-stage program-counter controller: boot, sequential/branch/jump/jr redirect, stall and halt.
// Optional PC_PERF_CNT_EN adds cycle_cnt and fetch_cnt performance counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               reset,
    pc_sequencer_if.slave      bus,
    output logic [1:0]         dbg_state
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        fetch_cnt
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, STALLED, HALTED} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        fetch_valid_q;
    logic        halted_q;
    logic        active;
    logic        redirect;
    logic [31:0] br_target;
    logic [31:0] jump_target;
    logic [31:0] target;

    assign active      = (state == RUN) || (state == STALLED);
    assign br_target   = bus.d_pc + 32'd4 + {{14{bus.d_imm[15]}}, bus.d_imm[15:0], 2'b00};
    assign jump_target = {bus.d_pc[31:28], bus.d_imm, 2'b00};
    assign redirect    = active && !bus.stall && !bus.halt &&
                         (bus.npc_sel[1] || (bus.npc_sel == 2'b01 && bus.br_taken));

    // Only consulted when redirect is high, so the not-taken branch falls to the default.
    always_comb begin
        target = pc_q + 32'd4;
        case (bus.npc_sel)
            2'b01:   target = br_target;
            2'b10:   target = jump_target;
            2'b11:   target = bus.d_rs;
            default: target = pc_q + 32'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state         <= RUN;
                    fetch_valid_q <= 1'b1;
                end
                RUN, STALLED: begin
                    if (bus.stall) begin
                        state         <= STALLED;
                        fetch_valid_q <= 1'b0;
                    end else if (bus.halt) begin
                        state         <= HALTED;
                        fetch_valid_q <= 1'b0;
                        halted_q      <= 1'b1;
                    end else begin
                        state         <= RUN;
                        fetch_valid_q <= 1'b1;
                        pc_q          <= redirect ? target : pc_q + 32'd4;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= 32'd0;
            fetch_cnt <= 32'd0;
        end else begin
            if (active)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (fetch_valid_q)
                fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.halted      = halted_q;
    assign bus.redirect    = redirect;
    assign bus.link_addr   = bus.d_pc + 32'd8;
    assign dbg_state       = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; define PC_PERF_CNT_EN to also check the counters.
module tb_pc_sequencer;
    logic        clk;
    logic        reset;
    logic [1:0]  dbg_state;
    int          tests_run;
    int          tests_failed;
`ifdef PC_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] fetch_cnt;
`endif

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(32'h0000_3000)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef PC_PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt),
        .fetch_cnt (fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall    = 1'b0;
        bus.halt     = 1'b0;
        bus.npc_sel  = 2'b00;
        bus.br_taken = 1'b0;
        bus.d_pc     = 32'h0;
        bus.d_imm    = 26'h0;
        bus.d_rs     = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        tests_run++;
        if (bus.pc !== 32'h3000 || bus.fetch_valid !== 1'b0 || bus.halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: pc=%h fv=%b halted=%b expected pc=00003000 fv=0 halted=0",
                     bus.pc, bus.fetch_valid, bus.halted);
        end
        reset = 1'b0;
    endtask

    task automatic test_boot_sequential();
        logic [31:0] exp_pc [3];
        logic        exp_fv [3];
        exp_pc = '{32'h3000, 32'h3004, 32'h3008};
        exp_fv = '{1'b1, 1'b1, 1'b1};
        // First edge after reset leaves BOOT with pc unchanged.
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (bus.pc !== exp_pc[i] || bus.fetch_valid !== exp_fv[i]) begin
                tests_failed++;
                $display("FAIL seq_%0d: pc=%h fv=%b expected pc=%h fv=%b",
                         i, bus.pc, bus.fetch_valid, exp_pc[i], exp_fv[i]);
            end
        end
    endtask

    task automatic test_branch();
        bus.d_pc     = 32'h3008;
        bus.npc_sel  = 2'b01;
        bus.br_taken = 1'b1;
        bus.d_imm    = 26'h000FFFE;
        #1;
        tests_run++;
        if (bus.redirect !== 1'b1) begin
            tests_failed++;
            $display("FAIL branch_redirect: got %b expected 1", bus.redirect);
        end
        tick();
        tests_run++;
        if (bus.pc !== 32'h3004) begin
            tests_failed++;
            $display("FAIL branch_taken_pc: got %h expected 00003004", bus.pc);
        end
        bus.br_taken = 1'b0;
        #1;
        tests_run++;
        if (bus.redirect !== 1'b0) begin
            tests_failed++;
            $display("FAIL branch_not_taken_redirect: got %b expected 0", bus.redirect);
        end
        tick();
        tests_run++;
        if (bus.pc !== 32'h3008) begin
            tests_failed++;
            $display("FAIL branch_not_taken_pc: got %h expected 00003008", bus.pc);
        end
    endtask

    task automatic test_jal_jr();
        bus.d_pc    = 32'h3010;
        bus.d_imm   = 26'h0000C10;
        bus.npc_sel = 2'b10;
        #1;
        tests_run++;
        if (bus.link_addr !== 32'h3018 || bus.redirect !== 1'b1) begin
            tests_failed++;
            $display("FAIL jal_link: link=%h redirect=%b expected link=00003018 redirect=1",
                     bus.link_addr, bus.redirect);
        end
        tick();
        tests_run++;
        if (bus.pc !== 32'h3040) begin
            tests_failed++;
            $display("FAIL jal_pc: got %h expected 00003040", bus.pc);
        end
        bus.npc_sel = 2'b11;
        bus.d_rs    = 32'h3100;
        tick();
        tests_run++;
        if (bus.pc !== 32'h3100) begin
            tests_failed++;
            $display("FAIL jr_pc: got %h expected 00003100", bus.pc);
        end
    endtask

    task automatic test_target_boundaries();
        // Branch wraps past 2^32: fffffffc + 4 + 4 = 4.
        bus.npc_sel  = 2'b01;
        bus.br_taken = 1'b1;
        bus.d_pc     = 32'hFFFF_FFFC;
        bus.d_imm    = 26'h0000001;
        tick();
        tests_run++;
        if (bus.pc !== 32'h0000_0004) begin
            tests_failed++;
            $display("FAIL branch_wrap_pc: got %h expected 00000004", bus.pc);
        end
        // Most negative offset: 0x10000 + 4 - 0x20000.
        bus.d_pc  = 32'h0001_0000;
        bus.d_imm = 26'h3FF8000;
        tick();
        tests_run++;
        if (bus.pc !== 32'hFFFF_0004) begin
            tests_failed++;
            $display("FAIL branch_min_offset_pc: got %h expected ffff0004", bus.pc);
        end
        bus.npc_sel = 2'b10;
        bus.d_pc    = 32'hA123_4567;
        bus.d_imm   = 26'h3FFFFFF;
        tick();
        tests_run++;
        if (bus.pc !== 32'hAFFF_FFFC) begin
            tests_failed++;
            $display("FAIL jump_region_pc: got %h expected affffffc", bus.pc);
        end
        bus.npc_sel = 2'b11;
        bus.d_rs    = 32'h0000_3103;
        tick();
        tests_run++;
        if (bus.pc !== 32'h0000_3103) begin
            tests_failed++;
            $display("FAIL jr_unaligned_pc: got %h expected 00003103", bus.pc);
        end
        bus.npc_sel = 2'b11;
        bus.d_rs    = 32'h3100;
        tick();
    endtask

    task automatic test_stall();
        bus.npc_sel = 2'b10;
        bus.d_pc    = 32'h3010;
        bus.d_imm   = 26'h0000C10;
        bus.stall   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (bus.redirect !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_redirect_%0d: got %b expected 0", i, bus.redirect);
            end
            tick();
            tests_run++;
            if (bus.pc !== 32'h3100 || bus.fetch_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d: pc=%h fv=%b expected pc=00003100 fv=0",
                         i, bus.pc, bus.fetch_valid);
            end
        end
        bus.stall = 1'b0;
        #1;
        tests_run++;
        if (bus.redirect !== 1'b1) begin
            tests_failed++;
            $display("FAIL unstall_redirect: got %b expected 1", bus.redirect);
        end
        tick();
        tests_run++;
        if (bus.pc !== 32'h3040 || bus.fetch_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL unstall_jump: pc=%h fv=%b expected pc=00003040 fv=1",
                     bus.pc, bus.fetch_valid);
        end
        bus.npc_sel = 2'b00;
        tick();
        tests_run++;
        if (bus.pc !== 32'h3044) begin
            tests_failed++;
            $display("FAIL after_stall_seq: got %h expected 00003044", bus.pc);
        end
    endtask

    task automatic test_halt();
        bus.halt = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.halt     = i[0];
            bus.stall    = i[1];
            bus.npc_sel  = i[1:0];
            bus.br_taken = 1'b1;
            bus.d_rs     = 32'h0000_5000 + i;
            #1;
            tests_run++;
            if (bus.pc !== 32'h3044 || bus.halted !== 1'b1 || bus.fetch_valid !== 1'b0 ||
                bus.redirect !== 1'b0) begin
                tests_failed++;
                $display("FAIL halted_%0d: pc=%h halted=%b fv=%b redirect=%b expected pc=00003044 halted=1 fv=0 redirect=0",
                         i, bus.pc, bus.halted, bus.fetch_valid, bus.redirect);
            end
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        tests_run++;
        if (bus.pc !== 32'h3000 || bus.halted !== 1'b0 || bus.fetch_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_reset: pc=%h halted=%b fv=%b expected pc=00003000 halted=0 fv=0",
                     bus.pc, bus.halted, bus.fetch_valid);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (bus.pc !== 32'h3000 || bus.fetch_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_reboot: pc=%h fv=%b expected pc=00003000 fv=1",
                     bus.pc, bus.fetch_valid);
        end
    endtask

`ifdef PC_PERF_CNT_EN
    task automatic test_perf_counters();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tests_run++;
        if (cycle_cnt !== 32'd0 || fetch_cnt !== 32'd0) begin
            tests_failed++;
            $display("FAIL cnt_after_boot: cycle=%0d fetch=%0d expected 0 0", cycle_cnt, fetch_cnt);
        end
        // Five cycles spent in RUN (the last one sees stall rise), then two in STALLED.
        for (int i = 0; i < 4; i++) tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (cycle_cnt !== 32'd7 || fetch_cnt !== 32'd5) begin
            tests_failed++;
            $display("FAIL cnt_run_stall: cycle=%0d fetch=%0d expected 7 5", cycle_cnt, fetch_cnt);
        end
        bus.stall = 1'b0;
        bus.halt  = 1'b1;
        tick();
        bus.halt = 1'b0;
        tick();
        tick();
        tests_run++;
        if (cycle_cnt !== 32'd8 || fetch_cnt !== 32'd5) begin
            tests_failed++;
            $display("FAIL cnt_halted: cycle=%0d fetch=%0d expected 8 5", cycle_cnt, fetch_cnt);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_boot_sequential();
        test_branch();
        test_jal_jr();
        test_target_boundaries();
        test_stall();
        test_halt();
`ifdef PC_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

IF-stage program-counter controller for the five-stage MIPS pipeline. Owns the PC register, selects the next fetch address (sequential PC+4, branch, j/jal, jr), and applies stall, halt and boot sequencing. Sits between the hazard unit / D-stage decode and the instruction memory. Provides the link address for jal.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  from hazard unit; freezes PC; D-stage redirect ignored.
- halt  in  1  D-stage instruction is a stop instruction; sampled only when stall=0.
- npc_sel  in  2  D-stage next-PC kind: 00 seq, 01 branch, 10 j/jal, 11 jr.
- br_taken  in  1  branch comparator result; used only when npc_sel=01.
- d_pc  in  32  PC of the instruction in D.
- d_imm  in  26  instr[25:0] of the D instruction.
- d_rs  in  32  forwarded GPR[rs] for jr.
- pc  out  32  fetch address to IM (registered).
- fetch_valid  out  1  IF word at pc is a new fetch this cycle.
- redirect  out  1  combinational; a D-stage redirect is applied at the next edge.
- link_addr  out  32  d_pc + 8, combinational.
- halted  out  1  registered; high in HALTED.

## Operation
- States: BOOT, RUN, STALLED, HALTED. Reset: state=BOOT, pc=RESET_PC, fetch_valid=0, halted=0.
- BOOT: one cycle; pc held; fetch_valid=0; next state RUN (stall, halt, npc_sel ignored).
- RUN / STALLED, evaluated each cycle in priority order:
  1. stall=1: pc held; next STALLED; redirect=0; halt ignored.
  2. halt=1: pc held; next HALTED.
  3. redirect: pc <= target; next RUN.
  4. otherwise: pc <= pc + 4; next RUN.
- Targets (32-bit, wrap modulo 2^32, no overflow flag):
  - branch (npc_sel=01, br_taken=1): d_pc + 4 + (sign_extend(d_imm[15:0]) << 2).
  - j/jal (10): {d_pc[31:28], d_imm, 2'b00}.
  - jr (11): d_rs, used unmodified (no alignment check).
  - npc_sel=01 with br_taken=0 is sequential, redirect=0.
- redirect = (state is RUN or STALLED) & !stall & !halt & (npc_sel[1] | (npc_sel==01 & br_taken)).
- fetch_valid = 1 in RUN; 0 in BOOT, STALLED, HALTED.
- HALTED: pc frozen, halted=1, all inputs ignored; only reset exits.
- Delay slot: the instruction at d_pc+4 is already fetched when the redirect is applied; it is never squashed.

## Timing
- pc changes only on rising clk; a redirect decided in cycle t shows as pc in cycle t+1.
- First valid fetch: cycle 2 after reset deasserts (BOOT occupies cycle 1).
- Stall for N cycles holds pc for N cycles; sequential advance resumes in the cycle after stall falls.
- Reset mid-operation (any state, including HALTED): next cycle pc=RESET_PC, state=BOOT, counters cleared.
- redirect and link_addr are combinational from the D inputs; no registered latency.

## Configuration
- PC_PERF_CNT_EN defined: adds outputs cycle_cnt[31:0] (increments every cycle outside BOOT and HALTED) and fetch_cnt[31:0] (increments when fetch_valid=1). Both reset to 0 and wrap at 2^32.
- Not defined: no counters and no extra ports; all other behaviour is identical.

## Test plan
- Reset, then run 3 cycles with npc_sel=00: pc=0x3000 (fetch_valid=0), 0x3000 (fetch_valid=1), 0x3004, 0x3008.
- Branch: d_pc=0x3008, npc_sel=01, br_taken=1, d_imm[15:0]=16'hFFFE: redirect=1, next pc=0x3004. Repeat with br_taken=0: next pc=pc+4.
- jal: d_pc=0x3010, d_imm=26'h0000C10: next pc=0x0000_3040, link_addr=0x3018. jr with d_rs=0x3100: next pc=0x3100.
- stall=1 for 2 cycles together with npc_sel=10: pc held, fetch_valid=0, redirect=0. After stall drops with npc_sel=10 still asserted, the jump is taken next cycle.
- halt=1 in RUN: pc frozen and halted=1 for 10 cycles regardless of inputs. Reset returns pc to 0x3000 and halted to 0.
- PC_PERF_CNT_EN: 5 RUN cycles then 2 stall cycles gives cycle_cnt=7, fetch_cnt=5.
